// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable read-modify-write controller:
// FSM encoding, access-size codes and the word RAM geometry.
package mem_pkg;

  localparam int RAM_AW = 6;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_DAT  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Size code 3 has no meaning and is always rejected as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lsb[0];
      SZ_WORD: return (lsb != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: extracts and extends the addressed byte/halfword of
// a little-endian word for loads, and merges store data into that lane for stores.
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [4:0]  lane_lsb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign lane_lsb = {addr, 3'b000};
  assign byte_sel = word[lane_lsb +: 8];
  assign half_sel = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = word;
    merged   = wdata;
    case (size)
      SZ_BYTE: begin
        load_val = {{24{~uns & byte_sel[7]}}, byte_sel};
        merged   = word;
        merged[lane_lsb +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{~uns & half_sel[15]}}, half_sel};
        merged   = word;
        if (addr[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: begin
        load_val = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Load/store front end for a 64x32 synchronous word RAM: sub-word stores are
// done as read-modify-write, loads are lane-extracted and extended.
module mem_rmw_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [7:0]        req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_wea,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta
);

  // Handshakes: a request transfers on a clk edge with req_valid && req_ready,
  // a response on a clk edge with resp_valid && resp_ready; once raised, a
  // valid and its payload hold steady until that transfer edge.

  state_t state, state_nxt;

  logic        we_q, uns_q, err_q, wea_q;
  logic [1:0]  size_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q, rdata_q, dina_q;

  logic        accept, req_mis, req_word_st;
  logic [31:0] load_val, merged;

  assign accept      = req_valid & req_ready;
  assign req_mis     = is_misaligned(req_size, req_addr[1:0]);
  assign req_word_st = req_we & (req_size == SZ_WORD);

  byte_lane_unit u_lane (
    .word     (ram_douta),
    .addr     (addr_q[1:0]),
    .size     (size_q),
    .uns      (uns_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_mis)          state_nxt = S_RESP;
          else if (req_word_st) state_nxt = S_WR;
          else                  state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = S_DAT;
      S_DAT:   state_nxt = we_q ? S_WR : S_RESP;
      S_WR:    state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The write strobe is registered from the next state, so a reset on the
  // edge that would enter WR keeps the RAM untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wea_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= 8'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      dina_q  <= 32'd0;
    end else begin
      wea_q <= (state_nxt == S_WR);
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_mis;
        rdata_q <= 32'd0;
        if (req_word_st && !req_mis) dina_q <= req_wdata;
      end
      if (state == S_DAT) begin
        if (we_q) dina_q  <= merged;
        else      rdata_q <= load_val;
      end
    end
  end

  assign req_ready  = rst_n & (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ram_wea    = wea_q;
  assign ram_addr   = addr_q[7:2];
  assign ram_dina   = dina_q;

endmodule
